// File: rtl/camera_ahb_wr_master.sv
// AHB write master that moves camera pixel words from the bridge FIFO into one of three
// memory zones using INCR4 bursts and SINGLE tail transfers, then flags the zone as full.
module camera_ahb_wr_master #(
  parameter int unsigned OFFS_W = 22,
  parameter int unsigned THR    = 4
) (
  input  logic        HCLK,
  input  logic        HReset_N,
  output logic        mHBUSREQ,
  input  logic        mHGRANT,
  output logic [1:0]  mHTRANS,
  output logic [31:0] mHADDR,
  output logic        mHWRITE,
  output logic [2:0]  mHSIZE,
  output logic [2:0]  mHBURST,
  output logic [31:0] mHWDATA,
  input  logic        mHREADY,
  input  logic [1:0]  mHRESP,
  input  logic        CaptureEn,
  input  logic [31:0] BASE_ADDR_ZONE1,
  input  logic [31:0] BASE_ADDR_ZONE2,
  input  logic [31:0] BASE_ADDR_ZONE3,
  input  logic        DATAOK_ZONE1,
  input  logic        DATAOK_ZONE2,
  input  logic        DATAOK_ZONE3,
  input  logic [3:0]  FifoCnt,
  input  logic [31:0] FifoData,
  output logic        FifoPop,
  input  logic        FrameDone,
  output logic        DATAOK_ZONE1_Set,
  output logic        DATAOK_ZONE2_Set,
  output logic        DATAOK_ZONE3_Set,
  output logic [1:0]  CurrentZone,
  output logic        BusErr,
  output logic        FrameDrop
);

  localparam logic [1:0]        TransIdle   = 2'b00;
  localparam logic [1:0]        TransNonseq = 2'b10;
  localparam logic [1:0]        TransSeq    = 2'b11;
  localparam logic [2:0]        BurstSingle = 3'b000;
  localparam logic [2:0]        BurstIncr4  = 3'b011;
  localparam logic [1:0]        RespOkay    = 2'b00;
  localparam logic [OFFS_W-1:0] OffsStep    = OFFS_W'(4);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAddr,
    StLastData,
    StDrop
  } state_e;

  state_e            state_q;
  logic              done_q;
  logic [OFFS_W-1:0] offs_q;
  logic [OFFS_W-1:0] aoff_q;
  logic [1:0]        beat_q;
  logic              dphase_q;
  logic              incr4_q;

  logic [31:0]       zone_base;
  logic [31:0]       base_word;
  logic              zone_ok;
  logic              fifo_empty;
  logic              fifo_thr;
  logic              start_req;
  logic              frame_close;
  logic              resp_err;
  logic              data_done;
  logic              last_beat;
  logic [OFFS_W-1:0] aoff_nxt;

  always_comb begin
    zone_base = BASE_ADDR_ZONE1;
    zone_ok   = DATAOK_ZONE1;
    case (CurrentZone)
      2'd2: begin
        zone_base = BASE_ADDR_ZONE2;
        zone_ok   = DATAOK_ZONE2;
      end
      2'd3: begin
        zone_base = BASE_ADDR_ZONE3;
        zone_ok   = DATAOK_ZONE3;
      end
      default: ;
    endcase
  end

  // Zone bases are 16-byte aligned so an INCR4 from a zero offset never crosses a 1 KB line.
  assign base_word   = zone_base & 32'hFFFF_FFF0;
  assign fifo_empty  = (FifoCnt == 4'd0);
  assign fifo_thr    = ({28'd0, FifoCnt} >= THR);
  assign start_req   = CaptureEn & (fifo_thr | (done_q & ~fifo_empty));
  assign frame_close = done_q & fifo_empty;
  // Two-cycle ERROR/RETRY/SPLIT is caught on its first (HREADY low) cycle.
  assign resp_err    = dphase_q & (mHRESP != RespOkay) & ~mHREADY;
  assign data_done   = dphase_q & mHREADY;
  assign last_beat   = incr4_q ? (beat_q == 2'd3) : 1'b1;
  assign aoff_nxt    = aoff_q + OffsStep;

  assign FifoPop = data_done | ((state_q == StDrop) & ~fifo_empty);
  assign mHWDATA = dphase_q ? FifoData : 32'd0;
  assign mHSIZE  = 3'b010;

  always_ff @(posedge HCLK or negedge HReset_N) begin
    if (!HReset_N) begin
      state_q          <= StIdle;
      done_q           <= 1'b0;
      offs_q           <= '0;
      aoff_q           <= '0;
      beat_q           <= 2'd0;
      dphase_q         <= 1'b0;
      incr4_q          <= 1'b0;
      mHBUSREQ         <= 1'b0;
      mHTRANS          <= TransIdle;
      mHADDR           <= 32'd0;
      mHWRITE          <= 1'b0;
      mHBURST          <= BurstSingle;
      DATAOK_ZONE1_Set <= 1'b0;
      DATAOK_ZONE2_Set <= 1'b0;
      DATAOK_ZONE3_Set <= 1'b0;
      CurrentZone      <= 2'd1;
      BusErr           <= 1'b0;
      FrameDrop        <= 1'b0;
    end else begin
      DATAOK_ZONE1_Set <= 1'b0;
      DATAOK_ZONE2_Set <= 1'b0;
      DATAOK_ZONE3_Set <= 1'b0;
      BusErr           <= 1'b0;
      FrameDrop        <= 1'b0;
      done_q           <= done_q | FrameDone;
      if (data_done) begin
        offs_q <= offs_q + OffsStep;
      end

      case (state_q)
        StIdle: begin
          if (frame_close) begin
            case (CurrentZone)
              2'd2:    DATAOK_ZONE2_Set <= 1'b1;
              2'd3:    DATAOK_ZONE3_Set <= 1'b1;
              default: DATAOK_ZONE1_Set <= 1'b1;
            endcase
            CurrentZone <= (CurrentZone == 2'd3) ? 2'd1 : CurrentZone + 2'd1;
            offs_q      <= '0;
            // A FrameDone coinciding with the close belongs to the next frame.
            done_q      <= FrameDone;
          end else if (start_req) begin
            if ((offs_q == '0) && zone_ok) begin
              FrameDrop <= 1'b1;
              state_q   <= StDrop;
            end else begin
              mHBUSREQ <= 1'b1;
              state_q  <= StReq;
            end
          end
        end

        StReq: begin
          if (mHGRANT && mHREADY) begin
            state_q <= StAddr;
            mHTRANS <= TransNonseq;
            mHWRITE <= 1'b1;
            mHADDR  <= base_word + 32'(offs_q);
            mHBURST <= fifo_thr ? BurstIncr4 : BurstSingle;
            incr4_q <= fifo_thr;
            aoff_q  <= offs_q;
            beat_q  <= 2'd0;
          end
        end

        StAddr: begin
          if (resp_err) begin
            mHTRANS  <= TransIdle;
            mHWRITE  <= 1'b0;
            mHBUSREQ <= 1'b0;
            dphase_q <= 1'b0;
            BusErr   <= 1'b1;
            state_q  <= StDrop;
          end else if (mHREADY) begin
            dphase_q <= 1'b1;
            if (last_beat) begin
              mHTRANS <= TransIdle;
              state_q <= StLastData;
            end else begin
              beat_q  <= beat_q + 2'd1;
              aoff_q  <= aoff_nxt;
              mHADDR  <= base_word + 32'(aoff_nxt);
              mHTRANS <= TransSeq;
            end
          end
        end

        StLastData: begin
          if (resp_err) begin
            mHWRITE  <= 1'b0;
            mHBUSREQ <= 1'b0;
            dphase_q <= 1'b0;
            BusErr   <= 1'b1;
            state_q  <= StDrop;
          end else if (mHREADY) begin
            mHWRITE  <= 1'b0;
            mHBUSREQ <= 1'b0;
            dphase_q <= 1'b0;
            state_q  <= StIdle;
          end
        end

        StDrop: begin
          // Frame is discarded: drain it without bus traffic and keep the zone.
          if (frame_close) begin
            offs_q  <= '0;
            done_q  <= FrameDone;
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_ahb_wr_master.sv
// Directed bench for camera_ahb_wr_master: FIFO and AHB slave models, a bus/pop logger
// and hand-computed expectations for normal, tail, stall, drop, error and reset cases.
module tb_camera_ahb_wr_master;

  logic        HCLK;
  logic        HReset_N;
  logic        mHBUSREQ;
  logic        mHGRANT;
  logic [1:0]  mHTRANS;
  logic [31:0] mHADDR;
  logic        mHWRITE;
  logic [2:0]  mHSIZE;
  logic [2:0]  mHBURST;
  logic [31:0] mHWDATA;
  logic        mHREADY;
  logic [1:0]  mHRESP;
  logic        CaptureEn;
  logic [31:0] BASE_ADDR_ZONE1;
  logic [31:0] BASE_ADDR_ZONE2;
  logic [31:0] BASE_ADDR_ZONE3;
  logic        DATAOK_ZONE1;
  logic        DATAOK_ZONE2;
  logic        DATAOK_ZONE3;
  logic [3:0]  FifoCnt;
  logic [31:0] FifoData;
  logic        FifoPop;
  logic        FrameDone;
  logic        DATAOK_ZONE1_Set;
  logic        DATAOK_ZONE2_Set;
  logic        DATAOK_ZONE3_Set;
  logic [1:0]  CurrentZone;
  logic        BusErr;
  logic        FrameDrop;

  camera_ahb_wr_master dut (
    .HCLK             (HCLK),
    .HReset_N         (HReset_N),
    .mHBUSREQ         (mHBUSREQ),
    .mHGRANT          (mHGRANT),
    .mHTRANS          (mHTRANS),
    .mHADDR           (mHADDR),
    .mHWRITE          (mHWRITE),
    .mHSIZE           (mHSIZE),
    .mHBURST          (mHBURST),
    .mHWDATA          (mHWDATA),
    .mHREADY          (mHREADY),
    .mHRESP           (mHRESP),
    .CaptureEn        (CaptureEn),
    .BASE_ADDR_ZONE1  (BASE_ADDR_ZONE1),
    .BASE_ADDR_ZONE2  (BASE_ADDR_ZONE2),
    .BASE_ADDR_ZONE3  (BASE_ADDR_ZONE3),
    .DATAOK_ZONE1     (DATAOK_ZONE1),
    .DATAOK_ZONE2     (DATAOK_ZONE2),
    .DATAOK_ZONE3     (DATAOK_ZONE3),
    .FifoCnt          (FifoCnt),
    .FifoData         (FifoData),
    .FifoPop          (FifoPop),
    .FrameDone        (FrameDone),
    .DATAOK_ZONE1_Set (DATAOK_ZONE1_Set),
    .DATAOK_ZONE2_Set (DATAOK_ZONE2_Set),
    .DATAOK_ZONE3_Set (DATAOK_ZONE3_Set),
    .CurrentZone      (CurrentZone),
    .BusErr           (BusErr),
    .FrameDrop        (FrameDrop)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Show-ahead FIFO model fed by the stimulus.
  logic        push_req;
  logic [31:0] push_data;
  logic [31:0] fmem [0:15];
  logic [3:0]  wp;
  logic [3:0]  rp;
  logic [4:0]  fcnt;

  always @(posedge HCLK or negedge HReset_N) begin
    if (!HReset_N) begin
      wp   <= 4'd0;
      rp   <= 4'd0;
      fcnt <= 5'd0;
    end else begin
      if (push_req) begin
        fmem[wp] <= push_data;
        wp       <= wp + 4'd1;
      end
      if (FifoPop) begin
        rp <= rp + 4'd1;
      end
      fcnt <= fcnt + {4'd0, push_req} - {4'd0, FifoPop};
    end
  end

  assign FifoCnt  = fcnt[3:0];
  assign FifoData = fmem[rp];

  // Logger, sampled mid-cycle.
  logic [31:0] addr_log  [0:127];
  logic [1:0]  trans_log [0:127];
  logic [2:0]  burst_log [0:127];
  logic [31:0] pop_log   [0:127];
  int n_addr    = 0;
  int n_pop     = 0;
  int set1_cnt  = 0;
  int set2_cnt  = 0;
  int set3_cnt  = 0;
  int err_cnt   = 0;
  int drop_cnt  = 0;
  int pop_empty = 0;

  always @(negedge HCLK) begin
    if ((mHTRANS != 2'b00) && mHREADY) begin
      addr_log[7'(n_addr)]  <= mHADDR;
      trans_log[7'(n_addr)] <= mHTRANS;
      burst_log[7'(n_addr)] <= mHBURST;
      n_addr                <= n_addr + 1;
    end
    if (FifoPop) begin
      pop_log[7'(n_pop)] <= mHWDATA;
      n_pop              <= n_pop + 1;
      if (fcnt == 5'd0) pop_empty <= pop_empty + 1;
    end
    if (DATAOK_ZONE1_Set) set1_cnt <= set1_cnt + 1;
    if (DATAOK_ZONE2_Set) set2_cnt <= set2_cnt + 1;
    if (DATAOK_ZONE3_Set) set3_cnt <= set3_cnt + 1;
    if (BusErr)           err_cnt  <= err_cnt + 1;
    if (FrameDrop)        drop_cnt <= drop_cnt + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int f, input int i);
    return 32'hC000_0000 | 32'(f * 256 + i);
  endfunction

  task automatic push_frame(input int f, input int first, input int n, input bit with_done);
    for (int i = 0; i < n; i++) begin
      push_req  = 1'b1;
      push_data = word(f, first + i);
      @(posedge HCLK); #1;
    end
    push_req = 1'b0;
    if (with_done) begin
      FrameDone = 1'b1;
      @(posedge HCLK); #1;
      FrameDone = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int a0, p0, s1, s2, s3, e0, d0;
  bit found;

  initial begin
    HReset_N        = 1'b1;
    mHGRANT         = 1'b1;
    mHREADY         = 1'b1;
    mHRESP          = 2'b00;
    CaptureEn       = 1'b1;
    BASE_ADDR_ZONE1 = 32'h8000_0000;
    BASE_ADDR_ZONE2 = 32'h9000_0000;
    BASE_ADDR_ZONE3 = 32'hA000_0004;
    DATAOK_ZONE1    = 1'b0;
    DATAOK_ZONE2    = 1'b0;
    DATAOK_ZONE3    = 1'b0;
    push_req        = 1'b0;
    push_data       = 32'd0;
    FrameDone       = 1'b0;
    #1 HReset_N = 1'b0;
    #1;
    check_eq("rst_htrans", 32'(mHTRANS), 32'd0);
    check_eq("rst_busreq", 32'(mHBUSREQ), 32'd0);
    check_eq("rst_hwrite", 32'(mHWRITE), 32'd0);
    check_eq("rst_haddr", mHADDR, 32'd0);
    check_eq("rst_hwdata", mHWDATA, 32'd0);
    check_eq("rst_zone", 32'(CurrentZone), 32'd1);
    check_eq("rst_strobes", {26'd0, DATAOK_ZONE1_Set, DATAOK_ZONE2_Set, DATAOK_ZONE3_Set,
                             BusErr, FrameDrop, FifoPop}, 32'd0);
    check_eq("rst_hsize", 32'(mHSIZE), 32'd2);
    repeat (2) @(posedge HCLK);
    #1 HReset_N = 1'b1;
    @(posedge HCLK); #1;

    // Frame 1, zone 1: two INCR4 bursts.
    a0 = n_addr; p0 = n_pop; s1 = set1_cnt;
    push_frame(1, 0, 8, 1'b1);
    for (int k = 0; k < 200 && set1_cnt == s1; k++) begin @(posedge HCLK); #1; end
    repeat (3) @(posedge HCLK); #1;
    check_eq("a_naddr", 32'(n_addr - a0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("a_addr%0d", i), addr_log[7'(a0 + i)], 32'h8000_0000 + 32'(4 * i));
      check_eq($sformatf("a_trans%0d", i), 32'(trans_log[7'(a0 + i)]),
               (i % 4 == 0) ? 32'd2 : 32'd3);
      check_eq($sformatf("a_burst%0d", i), 32'(burst_log[7'(a0 + i)]), 32'd3);
      check_eq($sformatf("a_data%0d", i), pop_log[7'(p0 + i)], word(1, i));
    end
    check_eq("a_npop", 32'(n_pop - p0), 32'd8);
    check_eq("a_set1", 32'(set1_cnt - s1), 32'd1);
    check_eq("a_zone", 32'(CurrentZone), 32'd2);

    // Frame 2, zone 2: six words -> INCR4 plus two SINGLEs.
    a0 = n_addr; p0 = n_pop; s2 = set2_cnt;
    push_frame(2, 0, 6, 1'b1);
    for (int k = 0; k < 200 && set2_cnt == s2; k++) begin @(posedge HCLK); #1; end
    repeat (3) @(posedge HCLK); #1;
    check_eq("b_naddr", 32'(n_addr - a0), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("b_addr%0d", i), addr_log[7'(a0 + i)], 32'h9000_0000 + 32'(4 * i));
      check_eq($sformatf("b_trans%0d", i), 32'(trans_log[7'(a0 + i)]),
               (i == 0 || i >= 4) ? 32'd2 : 32'd3);
      check_eq($sformatf("b_burst%0d", i), 32'(burst_log[7'(a0 + i)]),
               (i < 4) ? 32'd3 : 32'd0);
      check_eq($sformatf("b_data%0d", i), pop_log[7'(p0 + i)], word(2, i));
    end
    check_eq("b_set2", 32'(set2_cnt - s2), 32'd1);
    check_eq("b_zone", 32'(CurrentZone), 32'd3);

    // Frame 3, zone 3 (base low bits ignored): stall beat 2 data phase for two cycles.
    a0 = n_addr; p0 = n_pop; s3 = set3_cnt;
    push_frame(3, 0, 4, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (mHADDR == 32'hA000_000C && mHTRANS == 2'b11) begin
        found = 1'b1;
        break;
      end
      @(posedge HCLK); #1;
    end
    check_eq("c_found", 32'(found), 32'd1);
    mHREADY = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check_eq($sformatf("c_stall_pop%0d", c), 32'(FifoPop), 32'd0);
      check_eq($sformatf("c_stall_addr%0d", c), mHADDR, 32'hA000_000C);
      check_eq($sformatf("c_stall_trans%0d", c), 32'(mHTRANS), 32'd3);
      check_eq($sformatf("c_stall_wdata%0d", c), mHWDATA, word(3, 2));
      @(posedge HCLK); #1;
    end
    mHREADY = 1'b1;
    #1;
    check_eq("c_release_pop", 32'(FifoPop), 32'd1);
    check_eq("c_release_wdata", mHWDATA, word(3, 2));
    for (int k = 0; k < 200 && set3_cnt == s3; k++) begin @(posedge HCLK); #1; end
    repeat (3) @(posedge HCLK); #1;
    check_eq("c_naddr", 32'(n_addr - a0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("c_addr%0d", i), addr_log[7'(a0 + i)], 32'hA000_0000 + 32'(4 * i));
      check_eq($sformatf("c_data%0d", i), pop_log[7'(p0 + i)], word(3, i));
    end
    check_eq("c_set3", 32'(set3_cnt - s3), 32'd1);
    check_eq("c_zone", 32'(CurrentZone), 32'd1);

    // Frame 4: zone 1 already full -> dropped.
    a0 = n_addr; p0 = n_pop; s1 = set1_cnt; d0 = drop_cnt;
    DATAOK_ZONE1 = 1'b1;
    push_frame(4, 0, 8, 1'b1);
    for (int k = 0; k < 200 && (n_pop - p0) < 8; k++) begin @(posedge HCLK); #1; end
    repeat (4) @(posedge HCLK); #1;
    check_eq("d_drop", 32'(drop_cnt - d0), 32'd1);
    check_eq("d_naddr", 32'(n_addr - a0), 32'd0);
    check_eq("d_npop", 32'(n_pop - p0), 32'd8);
    check_eq("d_set1", 32'(set1_cnt - s1), 32'd0);
    check_eq("d_zone", 32'(CurrentZone), 32'd1);
    check_eq("d_busreq", 32'(mHBUSREQ), 32'd0);
    DATAOK_ZONE1 = 1'b0;

    // Frame 5: ERROR on the third beat of the first burst.
    a0 = n_addr; p0 = n_pop; s1 = set1_cnt; e0 = err_cnt;
    push_frame(5, 0, 4, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (mHADDR == 32'h8000_000C && mHTRANS == 2'b11) begin
        found = 1'b1;
        break;
      end
      @(posedge HCLK); #1;
    end
    check_eq("e_found", 32'(found), 32'd1);
    mHREADY = 1'b0;
    mHRESP  = 2'b01;
    #1;
    check_eq("e_err_pop", 32'(FifoPop), 32'd0);
    @(posedge HCLK); #1;
    check_eq("e_htrans_idle", 32'(mHTRANS), 32'd0);
    check_eq("e_buserr", 32'(BusErr), 32'd1);
    check_eq("e_busreq", 32'(mHBUSREQ), 32'd0);
    mHREADY = 1'b1;
    @(posedge HCLK); #1;
    mHRESP = 2'b00;
    push_frame(5, 4, 4, 1'b1);
    for (int k = 0; k < 200 && (n_pop - p0) < 8; k++) begin @(posedge HCLK); #1; end
    repeat (4) @(posedge HCLK); #1;
    check_eq("e_naddr", 32'(n_addr - a0), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("e_addr%0d", i), addr_log[7'(a0 + i)], 32'h8000_0000 + 32'(4 * i));
    end
    check_eq("e_data0", pop_log[7'(p0)], word(5, 0));
    check_eq("e_data1", pop_log[7'(p0 + 1)], word(5, 1));
    check_eq("e_npop", 32'(n_pop - p0), 32'd8);
    check_eq("e_errcnt", 32'(err_cnt - e0), 32'd1);
    check_eq("e_set1", 32'(set1_cnt - s1), 32'd0);
    check_eq("e_zone", 32'(CurrentZone), 32'd1);

    // Frame 6: partial FIFO waits, CaptureEn gates starts, then async reset mid-burst.
    a0 = n_addr;
    push_frame(6, 0, 3, 1'b0);
    repeat (8) @(posedge HCLK); #1;
    check_eq("f_wait3_busreq", 32'(mHBUSREQ), 32'd0);
    check_eq("f_wait3_naddr", 32'(n_addr - a0), 32'd0);
    CaptureEn = 1'b0;
    push_frame(6, 3, 1, 1'b0);
    repeat (8) @(posedge HCLK); #1;
    check_eq("f_disabled_busreq", 32'(mHBUSREQ), 32'd0);
    check_eq("f_disabled_naddr", 32'(n_addr - a0), 32'd0);
    CaptureEn = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (mHTRANS == 2'b11) begin
        found = 1'b1;
        break;
      end
      @(posedge HCLK); #1;
    end
    check_eq("f_found", 32'(found), 32'd1);
    check_eq("f_first_addr", addr_log[7'(a0)], 32'h8000_0000);
    check_eq("f_hwrite", 32'(mHWRITE), 32'd1);
    check_eq("f_busreq", 32'(mHBUSREQ), 32'd1);
    #2 HReset_N = 1'b0;
    #1;
    check_eq("f_rst_htrans", 32'(mHTRANS), 32'd0);
    check_eq("f_rst_busreq", 32'(mHBUSREQ), 32'd0);
    check_eq("f_rst_haddr", mHADDR, 32'd0);
    check_eq("f_rst_hwrite", 32'(mHWRITE), 32'd0);
    check_eq("f_rst_hwdata", mHWDATA, 32'd0);
    check_eq("f_rst_zone", 32'(CurrentZone), 32'd1);
    repeat (2) @(posedge HCLK);
    #1 HReset_N = 1'b1;
    repeat (2) @(posedge HCLK); #1;
    check_eq("pop_when_empty", 32'(pop_empty), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
